// File: rtl/btn_pkg.sv
// Shared definitions for the button event generator.
// Holds the channel index constants, the per-channel FSM state encoding, the default
// 100 MHz cycle counts and a small helper used to size the hold counter.
package btn_pkg;

   // Channel indices into the button vectors.
   localparam int unsigned BTN_MODE   = 0;
   localparam int unsigned BTN_SET    = 1;
   localparam int unsigned BTN_TOGGLE = 2;
   localparam int unsigned BTN_CHANGE = 3;

   // Default timing for a 100 MHz clk.
   localparam int unsigned NUM_BTN_DEF     = 4;
   localparam int unsigned DEB_CYCLES_DEF  = 2_000_000;    // 20 ms
   localparam int unsigned LONG_CYCLES_DEF = 100_000_000;  // 1 s
   localparam int unsigned REP_CYCLES_DEF  = 20_000_000;   // 200 ms

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StHeld   = 2'd1,
      StRepeat = 2'd2
   } btn_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_event_gen_if.sv
// Button bus between the raw pads and the event consumers.
// Signals:
//   i_btn_in       raw asynchronous pads, active-high
//   o_level        debounced button state
//   o_press        1-cycle pulse on debounced 0->1
//   o_release      1-cycle pulse on debounced 1->0
//   o_long_press   1-cycle pulse LONG_CYCLES after press while held
//   o_repeat       1-cycle pulse every REP_CYCLES after long press while held
// Modports: slave = the event generator, master = the pad driver / event consumer.
interface btn_event_gen_if #(
   parameter int unsigned NUM_BTN = 4
);
   logic [NUM_BTN-1:0] i_btn_in;
   logic [NUM_BTN-1:0] o_level;
   logic [NUM_BTN-1:0] o_press;
   logic [NUM_BTN-1:0] o_release;
   logic [NUM_BTN-1:0] o_long_press;
   logic [NUM_BTN-1:0] o_repeat;

   modport master (
      output i_btn_in,
      input  o_level, o_press, o_release, o_long_press, o_repeat
   );

   modport slave (
      input  i_btn_in,
      output o_level, o_press, o_release, o_long_press, o_repeat
   );
endinterface

// File: rtl/btn_chan.sv
// One button channel: two-flop synchroniser, counting debouncer and press/long/repeat FSM.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   i_btn           raw pad
//   o_level         debounced state (registered)
//   o_press, o_release, o_long_press, o_repeat   registered 1-cycle events
module btn_chan
   import btn_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
   parameter int unsigned REP_CYCLES  = REP_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long_press,
   output logic o_repeat
);

   localparam int unsigned DCW  = $clog2(DEB_CYCLES);
   localparam int unsigned HCW  = $clog2(max_u(LONG_CYCLES, REP_CYCLES));
   localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
   localparam logic [HCW-1:0] LONG_LAST = HCW'(LONG_CYCLES - 1);
   localparam logic [HCW-1:0] REP_LAST  = HCW'(REP_CYCLES - 1);

   logic           r_s1, r_s2, r_stable;
   logic [DCW-1:0] r_dcnt;
   btn_state_e     r_state, w_state_d;
   logic [HCW-1:0] r_hcnt, w_hcnt_d;
   logic           r_press, r_release, r_long, r_repeat;
   logic           w_press_d, w_release_d, w_long_d, w_repeat_d;
   logic           w_flip, w_rise, w_fall;

   // Synchroniser and debouncer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_stable <= 1'b0;
         r_dcnt   <= '0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
         if (r_s2 == r_stable) begin
            r_dcnt <= '0;
         end else if (r_dcnt == DEB_LAST) begin
            r_stable <= r_s2;
            r_dcnt   <= '0;
         end else begin
            r_dcnt <= r_dcnt + DCW'(1);
         end
      end
   end

   // Flip decoded from the cycle the stable flop is about to change, so the event
   // register updates on the same edge as the level.
   assign w_flip = (r_s2 != r_stable) && (r_dcnt == DEB_LAST);
   assign w_rise = w_flip & r_s2;
   assign w_fall = w_flip & ~r_s2;

   always_comb begin
      w_state_d   = r_state;
      w_hcnt_d    = r_hcnt;
      w_press_d   = 1'b0;
      w_release_d = 1'b0;
      w_long_d    = 1'b0;
      w_repeat_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_rise) begin
               w_press_d = 1'b1;
               w_hcnt_d  = '0;
               w_state_d = StHeld;
            end
         end
         StHeld: begin
            // Release wins over a coincident long-press terminal count.
            if (w_fall) begin
               w_release_d = 1'b1;
               w_hcnt_d    = '0;
               w_state_d   = StIdle;
            end else if (r_hcnt == LONG_LAST) begin
               w_long_d  = 1'b1;
               w_hcnt_d  = '0;
               w_state_d = StRepeat;
            end else begin
               w_hcnt_d = r_hcnt + HCW'(1);
            end
         end
         StRepeat: begin
            if (w_fall) begin
               w_release_d = 1'b1;
               w_hcnt_d    = '0;
               w_state_d   = StIdle;
            end else if (r_hcnt == REP_LAST) begin
               w_repeat_d = 1'b1;
               w_hcnt_d   = '0;
            end else begin
               w_hcnt_d = r_hcnt + HCW'(1);
            end
         end
         default: begin
            w_hcnt_d  = '0;
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_hcnt    <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_hcnt    <= w_hcnt_d;
         r_press   <= w_press_d;
         r_release <= w_release_d;
         r_long    <= w_long_d;
         r_repeat  <= w_repeat_d;
      end
   end

   assign o_level      = r_stable;
   assign o_press      = r_press;
   assign o_release    = r_release;
   assign o_long_press = r_long;
   assign o_repeat     = r_repeat;

endmodule

// File: rtl/btn_event_gen.sv
// Multi-channel button conditioning: one independent btn_chan per button.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   bus        btn_event_gen_if slave: raw pads in, level and event pulses out
module btn_event_gen
   import btn_pkg::*;
#(
   parameter int unsigned NUM_BTN     = NUM_BTN_DEF,
   parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
   parameter int unsigned REP_CYCLES  = REP_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst,
   btn_event_gen_if.slave  bus
);

   logic [NUM_BTN-1:0] w_btn_in;
   logic [NUM_BTN-1:0] w_level, w_press, w_release, w_long, w_repeat;

   assign w_btn_in = bus.i_btn_in;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
      btn_chan #(
         .DEB_CYCLES  (DEB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES),
         .REP_CYCLES  (REP_CYCLES)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .i_btn        (w_btn_in[g]),
         .o_level      (w_level[g]),
         .o_press      (w_press[g]),
         .o_release    (w_release[g]),
         .o_long_press (w_long[g]),
         .o_repeat     (w_repeat[g])
      );
   end

   assign bus.o_level      = w_level;
   assign bus.o_press      = w_press;
   assign bus.o_release    = w_release;
   assign bus.o_long_press = w_long;
   assign bus.o_repeat     = w_repeat;

endmodule
